generador_obstaculos: RTL and testbench

//   Produces the 3-lane x 7-column obstacle field disp_obs[20:0] that the game FSM and display consume.

---
 rtl/generador_obstaculos.sv | 132 +++++++++++++
 tb/tb_generador_obstaculos.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_obstaculos.sv
// Scrolling 3-lane x 7-column obstacle field with LFSR spawning,
// collision pulse and saturating dodge counter.
module generador_obstaculos #(
  parameter int          TICK_DIV  = 2_700_000,
  parameter int          SPAWN_GAP = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [2:0]  heroe,
  output logic [20:0] disp_obs,
  output logic        step,
  output logic        choque,
  output logic [7:0]  pasados
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int GW =
    (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX =
    GW'(SPAWN_GAP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   disp_q, disp_d;
  logic          step_q, step_d;
  logic          choque_q, choque_d;
  logic [7:0]    pas_q, pas_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          hit_q, hit_d;

  logic          tick;
  logic          fb;
  logic          hit_nx;
  logic [2:0]    col0;
  logic [2:0]    pat;
  logic [2:0]    p;
  logic [20:0]   disp_s;

  always_comb begin
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    step_d   = 1'b0;
    choque_d = 1'b0;
    pas_d    = pas_q;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    hit_d    = hit_q;
    hit_nx   = 1'b0;

    tick = (cnt_q == CNT_MAX);
    col0 = {disp_q[14], disp_q[7], disp_q[0]};
    fb   = lfsr_q[15] ^ lfsr_q[13]
         ^ lfsr_q[12] ^ lfsr_q[10];

    // never block all three lanes at once
    pat = (lfsr_q[2:0] == 3'b111) ?
          3'b110 : lfsr_q[2:0];
    p   = (gap_q != '0) ? 3'b000 : pat;

    disp_s = '0;
    for (int l = 0; l < 3; l++) begin
      disp_s[l*7 +: 7] =
        {p[l], disp_q[l*7+1 +: 6]};
    end

    if (clear) begin
      cnt_d  = '0;
      disp_d = '0;
      pas_d  = '0;
      gap_d  = '0;
      hit_d  = 1'b0;
    end else if (enable) begin
      if (tick) begin
        cnt_d  = '0;
        disp_d = disp_s;
        step_d = 1'b1;
        lfsr_d = {lfsr_q[14:0], fb};
        if (gap_q != '0)
          gap_d = gap_q - 1'b1;
        else if (p != 3'b000)
          gap_d = GAP_MAX;
        else
          gap_d = '0;
        if (col0 != 3'b000 &&
            (col0 & heroe) == 3'b000 &&
            pas_q != 8'hFF)
          pas_d = pas_q + 8'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // judged on the field being loaded now,
      // so a scroll hit lines up with step
      hit_nx = |({disp_d[14], disp_d[7],
                  disp_d[0]} & heroe);
      hit_d    = hit_nx;
      choque_d = hit_nx & ~hit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      disp_q   <= '0;
      step_q   <= 1'b0;
      choque_q <= 1'b0;
      pas_q    <= '0;
      gap_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      hit_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      step_q   <= step_d;
      choque_q <= choque_d;
      pas_q    <= pas_d;
      gap_q    <= gap_d;
      lfsr_q   <= lfsr_d;
      hit_q    <= hit_d;
    end
  end

  assign disp_obs = disp_q;
  assign step     = step_q;
  assign choque   = choque_q;
  assign pasados  = pas_q;

endmodule

// File: tb/tb_generador_obstaculos.sv
// Directed bench for generador_obstaculos with a
// small field model for the pseudo-random stretches.
module tb_generador_obstaculos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [2:0]  heroe;
  logic [20:0] disp_obs;
  logic        step;
  logic        choque;
  logic [7:0]  pasados;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  m_cnt;
  logic [20:0] m_disp;
  logic [15:0] m_lfsr;
  int          m_gap;
  logic [7:0]  m_pas;

  generador_obstaculos #(
    .TICK_DIV (4),
    .SPAWN_GAP(1),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clear   (clear),
    .heroe   (heroe),
    .disp_obs(disp_obs),
    .step    (step),
    .choque  (choque),
    .pasados (pasados)
  );

  always #5 clk = ~clk;

  task automatic m_scroll(input logic [2:0] h);
    logic [2:0] c0;
    logic [2:0] p;
    logic       fb;
    c0 = {m_disp[14], m_disp[7], m_disp[0]};
    if (c0 != 0 && (c0 & h) == 0 && m_pas != 8'd255)
      m_pas = m_pas + 8'd1;
    if (m_gap > 0) begin
      p = 3'b000;
      m_gap = m_gap - 1;
    end else begin
      p = m_lfsr[2:0];
      if (p == 3'b111) p = 3'b110;
      if (p != 0) m_gap = 1;
    end
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 6; c++)
        m_disp[l*7+c] = m_disp[l*7+c+1];
      m_disp[l*7+6] = p[l];
    end
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  // predict the coming edge, then move to the next negedge
  task automatic adv();
    if (!rst_n) begin
      m_cnt = 0; m_disp = 0; m_pas = 0;
      m_gap = 0; m_lfsr = 16'hACE1;
    end else if (clear) begin
      m_cnt = 0; m_disp = 0; m_pas = 0; m_gap = 0;
    end else if (enable) begin
      if (m_cnt == 3) begin
        m_scroll(heroe);
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; heroe = 3'b001;
    adv(); adv();
    n_chk++;
    if (disp_obs !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_disp got=%h exp=0", disp_obs);
    end
    n_chk++;
    if (step !== 1'b0 || choque !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses step=%b choque=%b exp=0",
               step, choque);
    end
    n_chk++;
    if (pasados !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_pasados got=%0d exp=0", pasados);
    end
    rst_n = 1'b1; enable = 1'b0; heroe = 3'b000;
    adv();
  endtask

  task automatic test_first_spawn();
    logic exp_step;
    enable = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      adv();
      exp_step = (j % 4 == 0);
      n_chk++;
      if (step !== exp_step) begin
        n_fail++;
        $display("FAIL spawn_step j=%0d got=%b exp=%b",
                 j, step, exp_step);
      end
      if (j == 4 || j == 8 || j == 12) begin
        n_chk++;
        if (disp_obs !== (j == 4 ? 21'h000040 :
                          j == 8 ? 21'h000020 : 21'h102010)) begin
          n_fail++;
          $display("FAIL spawn_disp j=%0d got=%h", j, disp_obs);
        end
      end
    end
  endtask

  task automatic test_collide_scroll();
    heroe = 3'b001;
    for (int s = 4; s <= 8; s++) begin
      for (int k = 0; k < 4; k++) begin
        adv();
        if (k == 0 && s == 8) begin
          n_chk++;
          if (choque !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_single got=%b exp=0", choque);
          end
        end
      end
      n_chk++;
      if (choque !== (s == 7) || step !== 1'b1) begin
        n_fail++;
        $display("FAIL collide_pulse s=%0d choque=%b step=%b",
                 s, choque, step);
      end
      n_chk++;
      if (disp_obs !== m_disp) begin
        n_fail++;
        $display("FAIL collide_disp got=%h exp=%h",
                 disp_obs, m_disp);
      end
    end
    n_chk++;
    if (pasados !== 8'd0) begin
      n_fail++;
      $display("FAIL collide_pasados got=%0d exp=0", pasados);
    end
  endtask

  task automatic test_hero_move();
    bit found = 0;
    heroe = 3'b000;
    for (int s = 0; s < 80 && !found; s++) begin
      for (int k = 0; k < 4; k++) adv();
      if (m_disp[14] && !m_disp[7]) found = 1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL move_search got=none exp=bit14_set");
    end else begin
      heroe = 3'b010;
      adv();
      n_chk++;
      if (choque !== 1'b0) begin
        n_fail++;
        $display("FAIL move_free got=%b exp=0", choque);
      end
      heroe = 3'b100;
      adv();
      n_chk++;
      if (choque !== 1'b1) begin
        n_fail++;
        $display("FAIL move_hit got=%b exp=1", choque);
      end
      adv();
      n_chk++;
      if (choque !== 1'b0) begin
        n_fail++;
        $display("FAIL move_hold got=%b exp=0", choque);
      end
      adv();
      n_chk++;
      if (choque !== 1'b0 || step !== 1'b1) begin
        n_fail++;
        $display("FAIL move_after choque=%b step=%b exp 0/1",
                 choque, step);
      end
    end
  endtask

  task automatic test_saturate();
    logic [2:0] c0;
    int extra = 0;
    for (int s = 0; s < 2000 && extra < 20; s++) begin
      for (int k = 0; k < 4; k++) begin
        c0 = {m_disp[14], m_disp[7], m_disp[0]};
        heroe = !c0[0] ? 3'b001 : !c0[1] ? 3'b010 : 3'b100;
        adv();
      end
      n_chk++;
      if (disp_obs !== m_disp || pasados !== m_pas) begin
        n_fail++;
        $display("FAIL sat_track s=%0d disp=%h/%h pas=%0d/%0d",
                 s, disp_obs, m_disp, pasados, m_pas);
      end
      if (m_pas == 8'd255) extra++;
    end
    n_chk++;
    if (pasados !== 8'hFF || extra < 20) begin
      n_fail++;
      $display("FAIL sat_hold got=%0d exp=255 extra=%0d",
               pasados, extra);
    end
  endtask

  task automatic test_freeze();
    logic [20:0] snap_d;
    logic [7:0]  snap_p;
    int n;
    heroe = 3'b000;
    adv(); adv();
    snap_d = m_disp; snap_p = m_pas;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adv();
      n_chk++;
      if (step !== 1'b0 || disp_obs !== snap_d ||
          pasados !== snap_p) begin
        n_fail++;
        $display("FAIL freeze i=%0d step=%b disp=%h pas=%0d",
                 i, step, disp_obs, pasados);
      end
    end
    enable = 1'b1;
    n = 0;
    do begin
      adv();
      n++;
    end while (step !== 1'b1 && n < 8);
    n_chk++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL freeze_resume got=%0d exp=2", n);
    end
    n_chk++;
    if (disp_obs !== m_disp) begin
      n_fail++;
      $display("FAIL freeze_disp got=%h exp=%h", disp_obs, m_disp);
    end
  endtask

  task automatic test_clear();
    heroe = 3'b000;
    adv(); adv(); adv();
    clear = 1'b1;
    adv();
    clear = 1'b0;
    n_chk++;
    if (disp_obs !== 21'h0 || pasados !== 8'd0 ||
        step !== 1'b0) begin
      n_fail++;
      $display("FAIL clear disp=%h pas=%0d step=%b exp 0",
               disp_obs, pasados, step);
    end
    for (int k = 0; k < 4; k++) adv();
    n_chk++;
    if (step !== 1'b1 || disp_obs !== m_disp) begin
      n_fail++;
      $display("FAIL clear_respawn step=%b got=%h exp=%h",
               step, disp_obs, m_disp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; heroe = 3'b000;
    @(negedge clk);
    test_reset();
    test_first_spawn();
    test_collide_scroll();
    test_hero_move();
    test_saturate();
    test_freeze();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
